// File: rtl/tx_control_unit.sv
// -----------------------------------------------------------------------------
// tx_control_unit
//   UART transmit-side control and shift unit. Takes a parallel word through a
//   valid/ready handshake and serialises it on TXD as: start bit, SIZE data
//   bits LSB first, optional parity bit, STOP_BITS stop bits. Bit timing is
//   paced by the external one-cycle BAUD_TICK enable; single clock domain.
//
// Parameters
//   SIZE        data bits per frame (1..16)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  parity sense when PARITY_EN=1 (0 = even, 1 = odd)
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   BAUD_TICK  one-CLK pulse per bit period
//   TX_VALID   TX_DATA holds a word to send
//   TX_DATA    word to transmit (sampled only at accept)
//   TX_READY   block can accept a word this cycle
//   TXD        registered serial line, idles high
//   TX_BUSY    a frame is pending or in progress
//   TX_DONE    one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module tx_control_unit #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            BAUD_TICK,
  input  logic            TX_VALID,
  input  logic [SIZE-1:0] TX_DATA,
  output logic            TX_READY,
  output logic            TXD,
  output logic            TX_BUSY,
  output logic            TX_DONE
);

  localparam int unsigned CW       = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic        ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic [SIZE-1:0] shift;
  logic [CW-1:0]   bit_cnt;
  logic            stop_cnt;
  logic            parity;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
      TXD      <= 1'b1;
      TX_BUSY  <= 1'b0;
      TX_READY <= 1'b1;
      TX_DONE  <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          // A tick in the accept cycle is deliberately not acted on: ARMED
          // waits for the next one before driving the start bit.
          if (TX_VALID && TX_READY) begin
            shift    <= TX_DATA;
            parity   <= (^TX_DATA) ^ ODD_BIT;
            state    <= S_ARMED;
            TX_BUSY  <= 1'b1;
            TX_READY <= 1'b0;
          end
        end
        S_ARMED: begin
          if (BAUD_TICK) begin
            TXD   <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (BAUD_TICK) begin
            TXD     <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (BAUD_TICK) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                TXD   <= parity;
                state <= S_PARITY;
              end else begin
                TXD      <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              TXD   <= shift[0];
              shift <= shift >> 1;
            end
          end
        end
        S_PARITY: begin
          if (BAUD_TICK) begin
            TXD      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (BAUD_TICK) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= S_IDLE;
              TX_DONE  <= 1'b1;
              TX_BUSY  <= 1'b0;
              TX_READY <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          TXD      <= 1'b1;
          TX_BUSY  <= 1'b0;
          TX_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule
